// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider family and its monitor.
package clk_div_pkg;

    // Monitor FSM states.
    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        MEAS
    } mon_state_e;

    // Half-cycle counter add that sticks at max_val instead of wrapping.
    function automatic int unsigned half_sat_add(input int unsigned a,
                                                 input int unsigned b,
                                                 input int unsigned max_val);
        int unsigned s;
        s = a + b;
        return (s > max_val) ? max_val : s;
    endfunction

endpackage

// File: rtl/clk_div_monitor_sampler.sv
// Samples the divided clock in both halves of clk and flags rising edges.
// Output pair (h, l) describes the previous clk period; rise_* are relative
// to the low-half sample of the period before that (prev_l).
module clk_half_sampler (
    input  logic clk,
    input  logic reset,
    input  logic div_clk_in,
    output logic h,
    output logic l,
    output logic rise_h,
    output logic rise_l
);

    logic s_neg;
    logic s_pos;
    logic h_q;
    logic prev_l;

    // Capture the clk-high-half value at the falling edge of clk.
    always_ff @(negedge clk) begin
        if (reset) begin
            s_neg <= 1'b0;
        end else begin
            s_neg <= div_clk_in;
        end
    end

    // Capture the clk-low-half value, align the high-half sample, keep prev l.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_pos  <= 1'b0;
            h_q    <= 1'b0;
            prev_l <= 1'b0;
        end else begin
            s_pos  <= div_clk_in;
            h_q    <= s_neg;
            prev_l <= s_pos;
        end
    end

    // Edge decode over the ordered halves prev_l -> h -> l.
    always_comb begin
        h      = h_q;
        l      = s_pos;
        rise_h = h_q & ~prev_l;
        rise_l = ~h_q & s_pos;
    end

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock in clk half-cycles,
// tracks lock and raises sticky period/duty/stuck errors.
import clk_div_pkg::*;

module clk_div_monitor #(
    parameter int unsigned EXP_PERIOD = 3,
    parameter int unsigned EXP_HIGH_H = 3,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned STUCK_H    = 64,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_clk_in,
    input  logic             en,
    input  logic             clr_err,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_h,
    output logic [CNT_W-1:0] high_h,
    output logic             locked,
    output logic             err_period,
    output logic             err_duty,
    output logic             err_stuck
);

    localparam int unsigned      CntMax     = (32'd1 << CNT_W) - 32'd1;
    localparam logic [CNT_W-1:0] ExpPeriodH = CNT_W'(2 * EXP_PERIOD);
    localparam logic [CNT_W-1:0] ExpHighH   = CNT_W'(EXP_HIGH_H);
    localparam logic [CNT_W-1:0] StuckH     = CNT_W'(STUCK_H);
    localparam logic [3:0]       LockCnt    = 4'(LOCK_COUNT);

    logic h, l, rise_h, rise_l;

    mon_state_e       state;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hacc;
    logic [3:0]       lock_cnt;

    logic [CNT_W-1:0] close_period, close_high;
    logic [CNT_W-1:0] acc_hcnt, acc_hacc;
    logic             stuck_hit, period_ok, high_ok;

    clk_half_sampler u_sampler (
        .clk        (clk),
        .reset      (reset),
        .div_clk_in (div_clk_in),
        .h          (h),
        .l          (l),
        .rise_h     (rise_h),
        .rise_l     (rise_l)
    );

    // Closed-period values, accumulate values and match/stuck decisions.
    always_comb begin
        close_period = hcnt;
        close_high   = hacc;
        if (rise_l) begin
            // Edge between h and l: the h half still belongs to the old period.
            close_period = CNT_W'(half_sat_add(32'(hcnt), 32'd1, CntMax));
            close_high   = CNT_W'(half_sat_add(32'(hacc), 32'(h), CntMax));
        end
        acc_hcnt  = CNT_W'(half_sat_add(32'(hcnt), 32'd2, CntMax));
        acc_hacc  = CNT_W'(half_sat_add(32'(hacc), 32'(h) + 32'(l), CntMax));
        // Fire once on crossing; saturation keeps it from re-firing.
        stuck_hit = (hcnt < StuckH) && (acc_hcnt >= StuckH);
        period_ok = (close_period == ExpPeriodH);
        high_ok   = (close_high == ExpHighH);
    end

    // Monitor FSM with registered measurement, lock and error outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hcnt       <= '0;
            hacc       <= '0;
            lock_cnt   <= '0;
            meas_valid <= 1'b0;
            period_h   <= '0;
            high_h     <= '0;
            locked     <= 1'b0;
            err_period <= 1'b0;
            err_duty   <= 1'b0;
            err_stuck  <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            // Error events below override this clear.
            if (clr_err) begin
                err_period <= 1'b0;
                err_duty   <= 1'b0;
                err_stuck  <= 1'b0;
            end
            if (!en) begin
                state    <= IDLE;
                hcnt     <= '0;
                hacc     <= '0;
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= ACQ;
                        hcnt  <= '0;
                        hacc  <= '0;
                    end
                    ACQ, MEAS: begin
                        if (rise_h || rise_l) begin
                            state <= MEAS;
                            hcnt  <= rise_h ? CNT_W'(2) : CNT_W'(1);
                            hacc  <= (rise_h && l) ? CNT_W'(2) : CNT_W'(1);
                            if (state == MEAS) begin
                                meas_valid <= 1'b1;
                                period_h   <= close_period;
                                high_h     <= close_high;
                                if (period_ok && high_ok) begin
                                    if (lock_cnt != LockCnt) begin
                                        lock_cnt <= lock_cnt + 4'd1;
                                    end
                                    if (lock_cnt >= LockCnt - 4'd1) begin
                                        locked <= 1'b1;
                                    end
                                end else begin
                                    lock_cnt <= '0;
                                    locked   <= 1'b0;
                                    if (!period_ok) begin
                                        err_period <= 1'b1;
                                    end
                                    if (!high_ok) begin
                                        err_duty <= 1'b1;
                                    end
                                end
                            end
                        end else begin
                            hcnt <= acc_hcnt;
                            hacc <= acc_hacc;
                            if (stuck_hit) begin
                                err_stuck <= 1'b1;
                                locked    <= 1'b0;
                                lock_cnt  <= '0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: the divided clock is described as a
// stream of half-cycle values; a reference model finds rising edges in that
// stream and derives periods, high times, lock and error flags.
module tb_clk_div_monitor;

    localparam int MaxC   = 255;
    localparam int StuckH = 64;
    localparam int LockN  = 4;
    localparam int ExpP   = 6;
    localparam int ExpH   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       div_clk_in = 1'b0;
    logic       en = 1'b0;
    logic       clr_err = 1'b0;
    logic       meas_valid;
    logic [7:0] period_h, high_h;
    logic       locked, err_period, err_duty, err_stuck;

    clk_div_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .div_clk_in (div_clk_in),
        .en         (en),
        .clr_err    (clr_err),
        .meas_valid (meas_valid),
        .period_h   (period_h),
        .high_h     (high_h),
        .locked     (locked),
        .err_period (err_period),
        .err_duty   (err_duty),
        .err_stuck  (err_stuck)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int tag;
        bit mv;
        int per;
        int hi;
        bit lk, ep, ed, es;
    } exp_t;
    typedef struct {
        int per;
        int hi;
    } meas_t;

    exp_t  cq[$];
    meas_t mq[$];
    int    nvec = 0;
    int    nmis = 0;
    bit    done = 1'b0;

    // Reference model state.
    bit m_active = 0, m_seeded = 0;
    int m_hc = 0, m_hi = 0, m_run = 0, m_per = 0, m_high = 0;
    bit m_ep = 0, m_ed = 0, m_es = 0;
    bit last_h = 0, last_l = 0, last_en = 0, pl = 0;

    // Half-stream generator: repeating pattern of g_p halves, first g_h high.
    int g_p = 6, g_h = 3, g_ph = 0, n_p = 6, n_h = 3;

    function automatic int sat(input int v);
        return (v > MaxC) ? MaxC : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        nvec++;
        if (act != exp_v) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic set_pat(input int p, input int hh);
        n_p = p;
        n_h = hh;
    endtask

    task automatic gen_half(output bit v);
        if (g_ph == 0) begin
            g_p = n_p;
            g_h = n_h;
        end
        v = (g_ph < g_h);
        g_ph = (g_ph + 1) % g_p;
    endtask

    // Evaluate the previous cycle's half pair; en_nx/rst_nx/clr_nx are the
    // controls of the current cycle. Result is the DUT state one cycle later.
    task automatic model_pair(input bit en_nx, input bit rst_nx, input bit clr_nx);
        exp_t x;
        bit   mv, rh, rl;
        int   per, hi, nh;
        mv = 0;
        if (rst_nx) begin
            m_active = 0; m_seeded = 0; m_hc = 0; m_hi = 0; m_run = 0;
            m_per = 0; m_high = 0; m_ep = 0; m_ed = 0; m_es = 0;
        end else begin
            if (clr_nx) begin
                m_ep = 0; m_ed = 0; m_es = 0;
            end
            if (!(last_en && en_nx)) begin
                m_active = 0;
                m_run = 0;
            end else begin
                if (!m_active) begin
                    m_active = 1; m_seeded = 0; m_hc = 0; m_hi = 0;
                end
                rh = last_h && !pl;
                rl = !last_h && last_l;
                if (rh || rl) begin
                    per = rh ? m_hc : sat(m_hc + 1);
                    hi  = rh ? m_hi : sat(m_hi + int'(last_h));
                    if (m_seeded) begin
                        mv = 1; m_per = per; m_high = hi;
                        mq.push_back('{per: per, hi: hi});
                        if (per == ExpP && hi == ExpH) begin
                            m_run++;
                        end else begin
                            m_run = 0;
                            if (per != ExpP) m_ep = 1;
                            if (hi != ExpH) m_ed = 1;
                        end
                    end
                    m_seeded = 1;
                    m_hc = rh ? 2 : 1;
                    m_hi = rh ? 1 + int'(last_l) : 1;
                end else begin
                    nh = sat(m_hc + 2);
                    if (m_hc < StuckH && nh >= StuckH) begin
                        m_es = 1;
                        m_run = 0;
                    end
                    m_hc = nh;
                    m_hi = sat(m_hi + int'(last_h) + int'(last_l));
                end
            end
        end
        x.tag = cyc + 1; x.mv = mv; x.per = m_per; x.hi = m_high;
        x.lk = (m_run >= LockN); x.ep = m_ep; x.ed = m_ed; x.es = m_es;
        cq.push_back(x);
    endtask

    // One clk cycle of stimulus; reset cycles drive the divided clock low.
    task automatic step(input bit e, input bit r, input bit c, input bit hv, input bit lv);
        bit hh, ll;
        hh = hv && !r;
        ll = lv && !r;
        @(posedge clk);
        #1;
        en = e; reset = r; clr_err = c; div_clk_in = hh;
        model_pair(e && !r, r, c);
        pl = last_l; last_h = hh; last_l = ll; last_en = e && !r;
        @(negedge clk);
        #1;
        div_clk_in = ll;
    endtask

    task automatic run(input int n, input bit e);
        bit hv, lv;
        for (int i = 0; i < n; i++) begin
            gen_half(hv);
            gen_half(lv);
            step(e, 1'b0, 1'b0, hv, lv);
        end
    endtask

    task automatic ctl(input bit e, input bit r, input bit c);
        bit hv, lv;
        gen_half(hv);
        gen_half(lv);
        step(e, r, c, hv, lv);
    endtask

    // Monitor: per-cycle flag check plus measurement pop on meas_valid.
    initial begin
        exp_t  x;
        meas_t m;
        forever begin
            @(posedge clk);
            #3;
            if (done) break;
            if (meas_valid) begin
                if (mq.size() == 0) begin
                    chk("meas_unexpected", 1, 0);
                end else begin
                    m = mq.pop_front();
                    chk("meas_period", int'(period_h), m.per);
                    chk("meas_high", int'(high_h), m.hi);
                end
            end
            while (cq.size() > 0 && cq[0].tag < cyc) void'(cq.pop_front());
            if (cq.size() > 0 && cq[0].tag == cyc) begin
                x = cq.pop_front();
                chk("meas_valid", int'(meas_valid), int'(x.mv));
                chk("period_h", int'(period_h), x.per);
                chk("high_h", int'(high_h), x.hi);
                chk("locked", int'(locked), int'(x.lk));
                chk("err_period", int'(err_period), int'(x.ep));
                chk("err_duty", int'(err_duty), int'(x.ed));
                chk("err_stuck", int'(err_stuck), int'(x.es));
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int p, hh, len;
        repeat (3) ctl(1'b0, 1'b1, 1'b0);
        run(2, 1'b0);
        g_ph = $urandom_range(0, 5);
        run(40, 1'b1);
        chk("div3_locked", int'(locked), 1);
        chk("div3_period", int'(period_h), 6);
        chk("div3_high", int'(high_h), 3);
        chk("div3_errs", int'({err_period, err_duty, err_stuck}), 0);
        set_pat(8, 4); run(3, 1'b1); set_pat(6, 3); run(6, 1'b1);
        chk("div4_err_period", int'(err_period), 1);
        run(30, 1'b1);
        ctl(1'b1, 1'b0, 1'b1);
        set_pat(6, 2); run(30, 1'b1);
        chk("posonly_err_duty", int'(err_duty), 1);
        chk("posonly_err_period", int'(err_period), 0);
        chk("posonly_locked", int'(locked), 0);
        ctl(1'b1, 1'b0, 1'b1);
        set_pat(6, 3); run(30, 1'b1);
        chk("relock", int'(locked), 1);
        set_pat(6, 0); run(40, 1'b1);
        chk("stuck_flag", int'(err_stuck), 1);
        chk("stuck_locked", int'(locked), 0);
        ctl(1'b1, 1'b0, 1'b1);
        run(10, 1'b1);
        chk("stuck_cleared", int'(err_stuck), 0);
        set_pat(6, 3); run(30, 1'b1);
        set_pat(6, 0); run(40, 1'b1);
        chk("stuck_again", int'(err_stuck), 1);
        set_pat(6, 3); run(20, 1'b1);
        ctl(1'b1, 1'b1, 1'b0);
        ctl(1'b1, 1'b1, 1'b0);
        run(1, 1'b1);
        chk("rst_outputs", int'({meas_valid, locked, err_period, err_duty, err_stuck}), 0);
        chk("rst_period", int'(period_h), 0);
        run(30, 1'b1);
        ctl(1'b0, 1'b0, 1'b0);
        run(1, 1'b1);
        chk("en_dip_locked", int'(locked), 0);
        run(30, 1'b1);
        chk("en_dip_relock", int'(locked), 1);
        for (int s = 0; s < 12; s++) begin
            p  = $urandom_range(4, 12);
            hh = ($urandom_range(0, 2) == 0) ? p / 2 : $urandom_range(1, p - 1);
            if (s % 3 == 0) begin
                p = 6; hh = 3;
            end
            if ($urandom_range(0, 5) == 0) hh = 0;
            set_pat(p, hh);
            len = $urandom_range(10, 40);
            for (int i = 0; i < len; i++) begin
                ctl($urandom_range(0, 15) != 0, 1'b0, $urandom_range(0, 19) == 0);
            end
        end
        run(4, 1'b1);
        @(posedge clk);
        #5;
        done = 1'b1;
        repeat (2) @(posedge clk);
        chk("meas_queue_drained", mq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Downstream checker for the odd-ratio 50%-duty clock dividers. It samples a divided clock on both edges of the source clock `clk` and measures its period and high time in half-cycles of `clk`. It reports each measurement, asserts lock after repeated in-spec periods, and raises sticky errors for wrong period, wrong duty or a stuck output. It sits beside every divider instance as a built-in self-check, and its `locked` flag gates enables for logic fed by the divided clock.

## Interface
- `EXP_PERIOD`, 3: expected divided period in `clk` cycles (≥2).
- `EXP_HIGH_H`, 3: expected high time in `clk` half-cycles.
- `LOCK_COUNT`, 4: consecutive matching periods required to assert `locked` (1..15).
- `STUCK_H`, 64: half-cycles without a rising edge before `err_stuck` (> 2·EXP_PERIOD).
- `CNT_W`, 8: width of half-cycle counters.

Ports:
- `clk` in 1: source clock; reset reset, synchronous, active-high; clock clk.
- `reset` in 1: synchronous, active-high.
- `div_clk_in` in 1: divided clock under test.
- `en` in 1: monitor enable.
- `clr_err` in 1: clears sticky error flags.
- `meas_valid` out 1: one-cycle pulse, new measurement present.
- `period_h` out CNT_W: last period in half-cycles.
- `high_h` out CNT_W: last high time in half-cycles.
- `locked` out 1: in-spec lock indicator.
- `err_period`, `err_duty`, `err_stuck` out 1 each: sticky error flags.

## Operation
- Sampling:
  - `s_neg` captures `div_clk_in` on negedge `clk` (the clk-high half value).
  - `s_pos` captures it on posedge `clk` (the clk-low half value).
  - All other logic runs on posedge `clk`.
- Each cycle, the core consumes an ordered half-sample pair (h, l) from the previous `clk` period, plus the stored previous l (`prev_l`).
- Rising edge at h: `prev_l`=0, h=1. Rising edge at l: h=0, l=1. At most one rising edge per pair is possible.
- Accumulators:
  - `hcnt`: halves since the last rising edge.
  - `hacc`: high halves since the last rising edge.
  - Both saturate at 2^CNT_W−1.
- No rising edge in the pair: `hcnt` += 2, `hacc` += h+l.
- Rising edge at h:
  - Closed period = `hcnt`, high = `hacc`.
  - Restart with `hcnt`=2, `hacc`=1+l.
- Rising edge at l:
  - Closed period = `hcnt`+1, high = `hacc`+h.
  - Restart with `hcnt`=1, `hacc`=1.
- FSM states:
  - IDLE: `en`=0. Counters are held at 0 and `locked`=0. Goes to ACQ when `en`=1.
  - ACQ: waits for the first rising edge, which only seeds the counters and produces no measurement. Goes to MEAS.
  - MEAS: every later rising edge registers `period_h` and `high_h` and pulses `meas_valid`.
  - `en`=0 in any state returns to IDLE.
- Match logic:
  - Match = (`period_h` == 2·EXP_PERIOD) and (`high_h` == EXP_HIGH_H).
  - A match increments the lock counter. When the counter reaches LOCK_COUNT, `locked` is set.
- A mismatch in MEAS:
  - Clears the lock counter and `locked`.
  - Sets `err_period` if the period differs, and `err_duty` if the high time differs. Both can set together.
- Stuck detection: when `hcnt` reaches STUCK_H in ACQ or MEAS:
  - Set `err_stuck` and clear `locked`.
  - Stay in the current state. Saturation prevents repeated wrap.
- Sticky errors are cleared only by `clr_err` or `reset`. If an error event and `clr_err` occur in the same cycle, the error wins.

## Timing
- Reset values: all outputs 0. FSM in IDLE, counters 0. `s_neg`, `s_pos` and `prev_l` are 0.
- Latency: a rising edge of `div_clk_in` during `clk` cycle k produces `meas_valid` high in cycle k+2.
- `period_h`, `high_h` and the error flags update on the same edge as `meas_valid`. `locked` updates on the same edge.
- `period_h` and `high_h` hold their values between pulses.
- Reset mid-measurement aborts immediately. The first measurement after reset needs two rising edges.

## Structure
- Shared package `clk_div_pkg`: the FSM state enum (IDLE, ACQ, MEAS) and a half-count saturating-add function. The existing dividers reuse the same package.
- Sub-module `clk_half_sampler`: holds the negedge/posedge sample flops and `prev_l`, and outputs h, l, `rise_h` and `rise_l`.

## Test plan
- Divide-by-3 source (pos/neg counters, OR output), `en`=1:
  - `period_h`=6 and `high_h`=3 on each pulse.
  - `locked`=1 on the 4th measurement; no errors.
- Divide-by-3 with posedge-only output (high_h 2):
  - `err_duty`=1, `err_period`=0, `locked` stays 0.
- Divide-by-4 into the default parameters:
  - `period_h`=8, `err_period`=1.
  - After locking at ratio 3, a single ratio-4 period drops `locked` in the same cycle as `meas_valid`.
- `div_clk_in` tied to 0 after lock:
  - `err_stuck`=1 once 64 halves pass without a rising edge; `locked`=0.
  - `clr_err` clears the flag for one cycle, then it re-asserts only on a new stuck event.
- `reset` asserted mid-period, then released:
  - All outputs 0 the next cycle.
  - The first `meas_valid` arrives only after the second rising edge.
- `en` toggled low for 1 cycle while locked:
  - `locked`=0 and the FSM returns to IDLE.
  - Re-lock takes 1 seed edge plus 4 matching periods.
